// File: rtl/cp0_regfile.sv
// CP0 system-control registers: Count/Compare timer, Status, Cause, EPC, BadVAddr.
// Handles mtc0/mfc0 access and M-stage exception/ERET commits with a one-cycle update latency.
module cp0_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT     = 32'h00;
  localparam logic [31:0] EXC_INT_FWD = 32'h02;
  localparam logic [31:0] EXC_ADEL    = 32'h04;
  localparam logic [31:0] EXC_ADES    = 32'h05;
  localparam logic [31:0] EXC_SYS     = 32'h08;
  localparam logic [31:0] EXC_BP      = 32'h09;
  localparam logic [31:0] EXC_RI      = 32'h0a;
  localparam logic [31:0] EXC_OV      = 32'h0c;
  localparam logic [31:0] EXC_ERET    = 32'h0e;
  localparam logic [31:0] EXC_INT_HW  = 32'h01;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] count_reg, compare_reg, status_reg, cause_reg, epc_reg, badvaddr_reg;
  logic        timer_int_reg, tick_reg;

  logic       exc_take, eret, addr_err;
  logic [4:0] exc_code;
  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // EXC_INT (0x00) is NOEXC; only the listed non-zero codes take an exception.
  always_comb begin
    exc_take = 1'b0;
    eret     = 1'b0;
    addr_err = 1'b0;
    exc_code = 5'd0;
    case (excepttype_i)
      EXC_INT_HW, EXC_INT_FWD: exc_take = 1'b1;
      EXC_ADEL, EXC_ADES: begin
        exc_take = 1'b1;
        addr_err = 1'b1;
        exc_code = excepttype_i[4:0];
      end
      EXC_SYS, EXC_BP, EXC_RI, EXC_OV: begin
        exc_take = 1'b1;
        exc_code = excepttype_i[4:0];
      end
      EXC_ERET: eret = 1'b1;
      default: ;
    endcase
  end

  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign wr_status  = we_i && (waddr_i == REG_STATUS);
  assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc     = we_i && (waddr_i == REG_EPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= 32'd0;
      compare_reg   <= 32'd0;
      status_reg    <= STATUS_RESET;
      cause_reg     <= 32'd0;
      epc_reg       <= 32'd0;
      badvaddr_reg  <= 32'd0;
      timer_int_reg <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      tick_reg <= ~tick_reg;
      if (wr_count)
        count_reg <= data_i;
      else if (tick_reg)
        count_reg <= count_reg + 32'd1;

      if (wr_compare)
        compare_reg <= data_i;

      // Rewriting Compare acknowledges the timer, even against a match this cycle.
      if (wr_compare)
        timer_int_reg <= 1'b0;
      else if ((count_reg == compare_reg) && (compare_reg != 32'd0))
        timer_int_reg <= 1'b1;

      cause_reg[15:10] <= {int_i[5] | timer_int_reg, int_i[4:0]};

      // An exception owns Status/Cause/EPC this cycle; mtc0 to them is dropped.
      if (exc_take) begin
        status_reg[1]   <= 1'b1;
        cause_reg[6:2]  <= exc_code;
        if (!status_reg[1]) begin
          epc_reg       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause_reg[31] <= is_in_delayslot_i;
        end
        if (addr_err)
          badvaddr_reg <= bad_addr_i;
      end else begin
        if (eret)
          status_reg[1] <= 1'b0;
        else if (wr_status)
          status_reg <= (status_reg & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        if (wr_cause)
          cause_reg[9:8] <= data_i[9:8];
        if (wr_epc)
          epc_reg <= data_i;
      end
    end
  end

  always_comb begin
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_reg;
      REG_COUNT:    data_o = count_reg;
      REG_COMPARE:  data_o = compare_reg;
      REG_STATUS:   data_o = status_reg;
      REG_CAUSE:    data_o = cause_reg;
      REG_EPC:      data_o = epc_reg;
      default:      data_o = 32'd0;
    endcase
  end

  assign count_o     = count_reg;
  assign compare_o   = compare_reg;
  assign status_o    = status_reg;
  assign cause_o     = cause_reg;
  assign epc_o       = epc_reg;
  assign badvaddr_o  = badvaddr_reg;
  assign timer_int_o = timer_int_reg;

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: we_i  in  1  mtc0 write enable.
REQ-004 SHALL have port: waddr_i  in  5  mtc0 CP0 register number.
REQ-005 SHALL have port: raddr_i  in  5  mfc0 CP0 register number.
REQ-006 SHALL have port: data_i  in  32  mtc0 write data.
REQ-007 SHALL have port: int_i  in  6  hardware interrupt lines.
REQ-008 SHALL have port: excepttype_i  in  32  exception code from the exception prioritiser, M stage.
REQ-009 SHALL have port: current_inst_addr_i  in  32  PC of the faulting instruction.
REQ-010 SHALL have port: is_in_delayslot_i  in  1  faulting instruction is in a branch delay slot.
REQ-011 SHALL have port: bad_addr_i  in  32  faulting data or fetch address.
REQ-012 SHALL have port: data_o  out  32  mfc0 read data.
REQ-013 SHALL have ports: count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  live register values.
REQ-014 SHALL have port: timer_int_o  out  1  timer interrupt pending.

Function
REQ-015 SHALL map registers as: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
REQ-016 SHALL make data_o a combinational read of raddr_i, returning 0 for unmapped numbers, with no bypass of same-cycle writes.
REQ-017 SHALL use these excepttype_i codes: NOEXC=0x00, INT=0x01, INT_FORWARD=0x02, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, OV=0x0c, ERET=0x0e.
REQ-018 SHALL map codes to Cause.ExcCode[6:2] as: INT and INT_FORWARD->0, ADEL->4, ADES->5, SYS->8, BP->9, RI->10, OV->12.
REQ-019 SHALL increment Count by 1 every second clock, using an internal toggle bit cleared by reset; Count wraps 0xFFFFFFFF->0.
REQ-020 SHALL, on an mtc0 to Count, load data_i and suppress that cycle's increment.
REQ-021 SHALL set timer_int_o when Count==Compare and Compare!=0; the flag is sticky.
REQ-022 SHALL clear timer_int_o on any mtc0 to Compare, and the clear SHALL win over a same-cycle match.
REQ-023 SHALL sample Cause[15:10] every cycle as int_i, except Cause[15]=int_i[5]|timer_int_o.
REQ-024 SHALL limit mtc0 writes to: Status bits [15:8],[1],[0]; Cause bits [9:8]; EPC all bits; Compare all bits; Count all bits.
REQ-025 SHALL ignore mtc0 writes to BadVAddr and to unmapped numbers.
REQ-026 SHALL, for any code other than NOEXC or ERET with Status.EXL=0, set EPC=current_inst_addr_i-4 and Cause.BD=1 if is_in_delayslot_i, else EPC=current_inst_addr_i and Cause.BD=0.
REQ-027 SHALL, for any code other than NOEXC or ERET with Status.EXL=1, leave EPC and Cause.BD unchanged.
REQ-028 SHALL, for any code other than NOEXC or ERET, set Status.EXL=1 and write Cause.ExcCode.
REQ-029 SHALL, for ADEL or ADES, also load BadVAddr=bad_addr_i.
REQ-030 SHALL, for ERET, clear Status.EXL and change nothing else.
REQ-031 SHALL give an exception or ERET update precedence over a same-cycle mtc0 write to the same register; mtc0 writes to other registers in that cycle SHALL still commit.
REQ-032 SHALL ignore unlisted excepttype_i values (no register change).
REQ-033 SHALL make all state changes visible on outputs the cycle after the triggering edge (latency 1).

Reset
REQ-034 SHALL, while rst=1 at a clock edge, force Status=0x00400000 (BEV=1), Count, Compare, Cause, EPC, BadVAddr and the toggle bit to 0, and timer_int_o=0.
REQ-035 SHALL have reset override all same-cycle writes and exceptions.
REQ-036 SHALL let reset asserted mid-exception leave no partial update.

Verification
REQ-037 SHALL cover: reset then 10 idle cycles -> status_o=0x00400000, count_o=5, timer_int_o=0.
REQ-038 SHALL cover: mtc0 Compare=0x20, Count=0x1E -> timer_int_o=1 four cycles later, cause_o[15]=1; then mtc0 Compare=0x100 -> timer_int_o=0 next cycle.
REQ-039 SHALL cover: excepttype_i=0x0c, PC=0xBFC00100, delayslot=1, EXL=0 -> epc_o=0xBFC000FC, cause_o[31]=1, cause_o[6:2]=12, status_o[1]=1.
REQ-040 SHALL cover: a second exception SYS with EXL=1 -> epc_o unchanged, ExcCode=8; then excepttype_i=0x0e -> status_o[1]=0.
REQ-041 SHALL cover: ADEL with bad_addr_i=0x80000003 and same-cycle mtc0 EPC=0x1234 -> badvaddr_o=0x80000003, epc_o=PC (exception wins).
REQ-042 SHALL cover: mtc0 Status=0xFFFFFFFF -> status_o=0x0040FF03; mtc0 BadVAddr -> unchanged.
